multi_channel_ranging_controller: RTL and testbench
===================================================

Name: multi_channel_ranging_controller

Overview:
Parametrised successor to the single-sensor ranging FSM. It sequences up to NUM_CH ultrasonic transducers round-robin, one active at a time to avoid crosstalk. For each channel it generates a timed trigger pulse, measures echo width with a timeout, and publishes a tagged result. It sits between the transducer pads (trigger and echo) and the distance/alarm logic.

Parameters:
NUM_CH, 4, number of sensor channels (1..16)
CNT_W, 16, echo width counter and result width
TRIG_CYCLES, 10, trigger pulse length in clk cycles (>=1)
TIMEOUT_CYCLES, 60000, no-echo and echo-too-long limit in cycles (< 2^CNT_W)
COOLDOWN_CYCLES, 2000, quiet gap after each channel before the next trigger (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run scanning; sampled only in IDLE
ch_mask  in  NUM_CH  per-channel enable; sampled at channel selection
echo_in  in  NUM_CH  raw echo inputs, asynchronous
trig_out  out  NUM_CH  one-hot trigger outputs
dist_valid  out  1  one-cycle result strobe
dist_count  out  CNT_W  echo width in cycles; held until next strobe
dist_ch  out  clog2(NUM_CH) (min 1)  channel of the result; held
dist_timeout  out  1  result is a timeout; held
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, channel pointer at NUM_CH-1 so the first pick is channel 0, counters 0, synchronisers 0.
- echo_in goes through a 2-FF synchroniser per channel (echo_s). Only the selected channel's echo_s is observed.
- IDLE: if enable=1 and ch_mask!=0, select the next set bit of ch_mask after the pointer, wrapping around, then go to TRIG. Otherwise stay in IDLE.
- TRIG: trig_out[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT with the timer cleared.
- WAIT: wait for a rising edge of echo_s (high now, low on the previous cycle). An echo already high on entry is ignored until it falls.
  - On a rising edge: go to MEASURE with count loaded to 1.
  - If the timer reaches TIMEOUT_CYCLES first: go to STORE with the timeout flag set and count = all ones.
- MEASURE: while echo_s=1, count increments; an echo N cycles wide yields count=N.
  - When echo_s=0: go to STORE.
  - If count reaches TIMEOUT_CYCLES while echo is still high: go to STORE with the timeout flag set and count = all ones.
- STORE (1 cycle): dist_valid=1 and dist_count, dist_ch, dist_timeout update together. Then go to COOLDOWN.
- COOLDOWN: wait COOLDOWN_CYCLES cycles, then go to IDLE.
- A channel's result appears TRIG_CYCLES + wait time + N + sync latency (2) + 1 cycles after the trigger begins.
- Dropping enable mid-measurement has no immediate effect: the current channel completes, then the block halts in IDLE.
- A ch_mask change takes effect at the next selection. A channel deasserted in the mask while it is active still completes.
- A single set mask bit re-measures the same channel every pass.
- Counters saturate and never wrap.
- Asserting reset_n low at any time returns the block to IDLE immediately, drives trig_out low, and clears all results.

Optional Feature:
Macro NEAREST_TRACK_EN.
- Defined: adds outputs nearest_count (CNT_W), nearest_ch, and sweep_done (1-cycle pulse).
  - Over one sweep (every channel in ch_mask measured once, ending when selection wraps past the highest set bit), the block tracks the minimum non-timeout dist_count and its channel.
  - sweep_done pulses in the STORE cycle of the last channel, with the nearest values valid that cycle and held afterwards.
  - A sweep where every channel timed out reports nearest_count = all ones and nearest_ch = 0.
  - Ties go to the lower channel number.
  - Reset value of all three outputs is 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
1. Defaults, ch_mask=4'b0001, enable=1, channel 0 echo of 500 cycles starting 300 cycles after trigger falls -> trig_out[0] high 10 cycles, dist_valid with dist_count=500, dist_ch=0, dist_timeout=0.
2. ch_mask=4'b1010, echoes 100/200 on channels 1/3 -> results in order ch1=100, ch3=200, ch1...; each pair of triggers separated by at least 2000 cycles; channels 0 and 2 never triggered.
3. No echo on channel 2 -> dist_valid 60000 cycles after entering WAIT with dist_timeout=1, dist_count=16'hFFFF. Echo held high 70000 cycles -> same timeout result.
4. Echo already high when WAIT is entered, falls, then rises for 50 cycles -> dist_count=50.
5. Deassert reset_n mid-TRIG and mid-MEASURE -> trig_out=0 immediately, all outputs 0, first pick after release is channel 0. Dropping enable in MEASURE -> result still produced, then busy=0.
6. NEAREST_TRACK_EN defined, mask 4'b1111, counts 400/150/timeout/150 -> sweep_done once, nearest_count=150, nearest_ch=1.

Source files
------------

// File: rtl/multi_channel_ranging_controller.sv
// Round-robin ultrasonic ranging sequencer: trigger, echo timing, tagged result.
// Define NEAREST_TRACK_EN to add per-sweep nearest-target outputs.
module multi_channel_ranging_controller #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 16,
  parameter int TRIG_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES  = 60000,
  parameter int COOLDOWN_CYCLES = 2000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] echo_in,
  output logic [NUM_CH-1:0] trig_out,
  output logic              dist_valid,
  output logic [CNT_W-1:0]  dist_count,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_timeout,
  output logic              busy
`ifdef NEAREST_TRACK_EN
  ,
  output logic [CNT_W-1:0]  nearest_count,
  output logic [CH_W-1:0]   nearest_ch,
  output logic              sweep_done
`endif
);

  localparam int TA = (TRIG_CYCLES > COOLDOWN_CYCLES)
                    ? TRIG_CYCLES : COOLDOWN_CYCLES;
  localparam int TM = (TA > TIMEOUT_CYCLES) ? TA : TIMEOUT_CYCLES;
  localparam int TMR_W = $clog2(TM + 1);

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LAST = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_STORE,
    S_COOL
  } state_t;

  state_t state, state_d;

  logic [NUM_CH-1:0] echo_m, echo_s;
  logic [CH_W-1:0]   ch, ch_d, pick, cand;
  logic              found;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  cnt;
  logic              echo_cur, echo_prev, echo_rise;
  logic              res_to;
  logic [CNT_W-1:0]  res_cnt;

  assign echo_cur  = echo_s[ch];
  assign echo_rise = echo_cur & ~echo_prev;
  assign ch_d      = (state == S_IDLE) ? pick : ch;
  assign busy      = (state != S_IDLE);

  // two-flop synchroniser on every raw echo pad
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
    end
  end

  // next enabled channel after the pointer, wrapping round
  always_comb begin
    pick  = ch;
    found = 1'b0;
    cand  = ch;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (int'(ch) + i >= NUM_CH)
        cand = CH_W'(int'(ch) + i - NUM_CH);
      else
        cand = CH_W'(int'(ch) + i);
      if (!found && ch_mask[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // result of the measurement that is about to be stored
  always_comb begin
    res_to  = (state == S_WAIT) | echo_cur;
    res_cnt = res_to ? '1 : cnt;
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:
        if (enable && (|ch_mask)) state_d = S_TRIG;
      S_TRIG:
        if (tmr == TRIG_LAST) state_d = S_WAIT;
      S_WAIT:
        if (echo_rise)              state_d = S_MEAS;
        else if (tmr == WAIT_LAST)  state_d = S_STORE;
      S_MEAS:
        if (!echo_cur || cnt >= CNT_LIM) state_d = S_STORE;
      S_STORE:
        state_d = S_COOL;
      S_COOL:
        if (tmr == COOL_LAST) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // channel pointer, timers, echo counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch           <= CH_W'(NUM_CH - 1);
      tmr          <= '0;
      cnt          <= '0;
      echo_prev    <= 1'b0;
      trig_out     <= '0;
      dist_valid   <= 1'b0;
      dist_count   <= '0;
      dist_ch      <= '0;
      dist_timeout <= 1'b0;
    end else begin
      echo_prev  <= echo_cur;
      dist_valid <= 1'b0;
      trig_out   <= '0;
      if (state_d == S_TRIG) begin
        ch             <= ch_d;
        trig_out[ch_d] <= 1'b1;
      end
      if (state_d == S_STORE) begin
        dist_valid   <= 1'b1;
        dist_count   <= res_cnt;
        dist_ch      <= ch;
        dist_timeout <= res_to;
      end
      if (state_d != state)
        tmr <= '0;
      else if (state inside {S_TRIG, S_WAIT, S_COOL})
        tmr <= tmr + 1'b1;
      if (state == S_WAIT && echo_rise)
        cnt <= CNT_W'(1);
      else if (state == S_MEAS && echo_cur && cnt < CNT_LIM)
        cnt <= cnt + 1'b1;
    end
  end

`ifdef NEAREST_TRACK_EN
  logic [CNT_W-1:0] run_cnt, best_cnt;
  logic [CH_W-1:0]  run_ch, best_ch, hi;
  logic             take, last;

  // running minimum and end-of-sweep detection
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_mask[i]) hi = CH_W'(i);
    take = !res_to &&
           (res_cnt < run_cnt ||
            (res_cnt == run_cnt && ch < run_ch));
    best_cnt = take ? res_cnt : run_cnt;
    best_ch  = take ? ch : run_ch;
    last     = (ch >= hi);
  end

  // publish the nearest target once per sweep
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt       <= '1;
      run_ch        <= '0;
      nearest_count <= '0;
      nearest_ch    <= '0;
      sweep_done    <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (state_d == S_STORE) begin
        if (last) begin
          nearest_count <= best_cnt;
          nearest_ch    <= best_ch;
          sweep_done    <= 1'b1;
          run_cnt       <= '1;
          run_ch        <= '0;
        end else begin
          run_cnt <= best_cnt;
          run_ch  <= best_ch;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_ranging_controller.sv
// Bench for multi_channel_ranging_controller: echo responder + result scoreboard.
// Shortened timeout/cooldown keep every scenario within a short run.
module tb_multi_channel_ranging_controller;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int TRIG = 10;
  localparam int TMO  = 600;
  localparam int COOL = 200;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    ch_mask = '0;
  logic [3:0]    echo_in = '0;
  logic [3:0]    trig_out;
  logic          dist_valid;
  logic [CW-1:0] dist_count;
  logic [1:0]    dist_ch;
  logic          dist_timeout;
  logic          busy;
`ifdef NEAREST_TRACK_EN
  logic [CW-1:0] nearest_count;
  logic [1:0]    nearest_ch;
  logic          sweep_done;
`endif

  multi_channel_ranging_controller #(
    .NUM_CH(NCH), .CNT_W(CW), .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO), .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ch_mask(ch_mask), .echo_in(echo_in),
    .trig_out(trig_out), .dist_valid(dist_valid),
    .dist_count(dist_count), .dist_ch(dist_ch),
    .dist_timeout(dist_timeout), .busy(busy)
`ifdef NEAREST_TRACK_EN
    , .nearest_count(nearest_count),
    .nearest_ch(nearest_ch), .sweep_done(sweep_done)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // per-channel echo behaviour and the result it must produce
  int            c_pre[4];
  int            c_dly[4];
  int            c_wid[4];
  logic [CW-1:0] c_cnt[4];
  logic          c_to[4];

  task automatic cfg(int c, int pre, int dly, int wid,
                     logic [CW-1:0] ec, logic et);
    c_pre[c] = pre; c_dly[c] = dly; c_wid[c] = wid;
    c_cnt[c] = ec;  c_to[c]  = et;
  endtask

  typedef struct {
    int ch; int pre; int dly; int wid;
    logic [CW-1:0] exp_cnt; logic exp_to;
  } vec_t;

  typedef struct {
    int ch; logic [CW-1:0] cnt; logic to;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   trig_log[$];
  int   cyc = 0;
  int   hi_len[4];
  int   last_fall = 0;
  bit   have_fall = 0;
  logic [3:0] trig_q = '0;
  bit   resp_busy = 0;
  int   sweep_cnt = 0;

  // trigger monitor and result checker
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      trig_q    = '0;
      have_fall = 0;
      for (int i = 0; i < 4; i++) hi_len[i] = 0;
    end else begin
      if (trig_out != 0)
        check("trig_onehot", $countones(trig_out), 1);
      for (int i = 0; i < 4; i++) begin
        if (trig_out[i] && !trig_q[i]) begin
          check("trig_in_mask", ch_mask[i], 1);
          if (have_fall) begin
            n_cmp++;
            if (cyc - last_fall < COOL) begin
              n_bad++;
              $display("FAIL trig_gap: got %0d cycles, required >= %0d",
                       cyc - last_fall, COOL);
            end
          end
          sb.push_back('{i, c_cnt[i], c_to[i]});
          trig_log.push_back(i);
          hi_len[i] = 0;
        end
        if (trig_out[i]) hi_len[i]++;
        if (!trig_out[i] && trig_q[i]) begin
          check("trig_len", hi_len[i], TRIG);
          last_fall = cyc;
          have_fall = 1;
        end
      end
      if (dist_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got ch %0d, expected none",
                   dist_ch);
        end else begin
          e = sb.pop_front();
          check("dist_ch", dist_ch, e.ch);
          check("dist_count", dist_count, e.cnt);
          check("dist_timeout", dist_timeout, e.to);
        end
      end
`ifdef NEAREST_TRACK_EN
      if (sweep_done) sweep_cnt++;
`endif
      trig_q = trig_out;
    end
  end

  // echo responder: reacts to each trigger using the channel's config
  initial begin
    int c, pre, dly, wid;
    forever begin
      @(negedge clk);
      if (reset_n && trig_out != 0) begin
        c = 0;
        for (int i = 0; i < 4; i++) if (trig_out[i]) c = i;
        pre = c_pre[c]; dly = c_dly[c]; wid = c_wid[c];
        resp_busy = 1;
        if (pre > 0) echo_in[c] = 1'b1;
        while (trig_out[c]) @(negedge clk);
        if (pre > 0) begin
          repeat (pre) @(negedge clk);
          echo_in[c] = 1'b0;
        end
        repeat (dly) @(negedge clk);
        if (wid > 0) begin
          echo_in[c] = 1'b1;
          repeat (wid) @(negedge clk);
          echo_in[c] = 1'b0;
        end
        resp_busy = 0;
      end
    end
  end

  task automatic wait_trig(output int c, input int budget);
    logic [3:0] prev;
    c = -1;
    prev = trig_out;
    for (int k = 0; k < budget && c < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (trig_out[i] && !prev[i]) c = i;
      prev = trig_out;
    end
    n_cmp++;
    if (c < 0) begin
      n_bad++;
      $display("FAIL trig_wait: got no trigger, required one in %0d cycles",
               budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy || resp_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy || resp_busy) begin
      n_bad++;
      $display("FAIL idle_wait: busy=%0b after %0d cycles, required 0",
               busy, budget);
    end
  endtask

  task automatic drive(logic [3:0] m, logic en);
    @(posedge clk);
    #1;
    ch_mask = m;
    enable  = en;
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_trig"}, trig_out, 0);
    check({tag, "_valid"}, dist_valid, 0);
    check({tag, "_count"}, dist_count, 0);
    check({tag, "_ch"}, dist_ch, 0);
    check({tag, "_timeout"}, dist_timeout, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef NEAREST_TRACK_EN
    check({tag, "_near_cnt"}, nearest_count, 0);
    check({tag, "_near_ch"}, nearest_ch, 0);
    check({tag, "_sweep"}, sweep_done, 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   c, n;
    int   got[4];

    vt[0] = '{0, 0, 300, 500, 16'd500, 1'b0};
    vt[1] = '{1, 0, 20, 100, 16'd100, 1'b0};
    vt[2] = '{3, 0, 50, 200, 16'd200, 1'b0};
    vt[3] = '{2, 0, 0, 0, 16'hFFFF, 1'b1};
    vt[4] = '{2, 0, 10, 700, 16'hFFFF, 1'b1};
    vt[5] = '{1, 0, 5, 1, 16'd1, 1'b0};
    vt[6] = '{0, 0, 0, 599, 16'd599, 1'b0};
    vt[7] = '{3, 40, 20, 50, 16'd50, 1'b0};
    for (int i = 0; i < 4; i++) cfg(i, 0, 0, 0, '1, 1'b1);

    repeat (3) @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // single-channel vectors
    for (int v = 0; v < 8; v++) begin
      cfg(vt[v].ch, vt[v].pre, vt[v].dly, vt[v].wid,
          vt[v].exp_cnt, vt[v].exp_to);
      drive(4'b0001 << vt[v].ch, 1'b1);
      wait_trig(c, 50);
      check("vec_ch", c, vt[v].ch);
      drive(4'b0001 << vt[v].ch, 1'b0);
      wait_idle(3000);
      check("vec_drained", sb.size(), 0);
    end

    // round robin over mask 1010
    cfg(1, 0, 20, 100, 16'd100, 1'b0);
    cfg(3, 0, 20, 200, 16'd200, 1'b0);
    n = trig_log.size();
    drive(4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) wait_trig(got[k], 2000);
    drive(4'b1010, 1'b0);
    wait_idle(3000);
    check("rr_0", got[0], 1);
    check("rr_1", got[1], 3);
    check("rr_2", got[2], 1);
    check("rr_3", got[3], 3);
    check("rr_count", trig_log.size() - n, 4);
    check("rr_drained", sb.size(), 0);

    // drop enable while measuring
    cfg(2, 0, 10, 200, 16'd200, 1'b0);
    drive(4'b0100, 1'b1);
    wait_trig(c, 50);
    repeat (80) @(posedge clk);
    #1 enable = 1'b0;
    wait_idle(3000);
    check("halt_drained", sb.size(), 0);
    n = trig_log.size();
    repeat (300) @(negedge clk);
    check("halt_busy", busy, 0);
    check("halt_no_retrig", trig_log.size(), n);

    // reset in the middle of a trigger pulse
    cfg(0, 0, 0, 0, '1, 1'b1);
    drive(4'b0001, 1'b1);
    wait_trig(c, 50);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check_cleared("rst_trig");
    sb.delete();
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset in the middle of a measurement
    cfg(1, 0, 10, 300, 16'd300, 1'b0);
    drive(4'b0010, 1'b1);
    wait_trig(c, 50);
    check("rst_meas_ch", c, 1);
    repeat (60) @(posedge clk);
    #1 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check_cleared("rst_meas");
    sb.delete();
    wait_idle(1000);
    cfg(0, 0, 10, 30, 16'd30, 1'b0);
    drive(4'b0011, 1'b0);
    #1 reset_n = 1'b1;
    drive(4'b0011, 1'b1);
    wait_trig(c, 50);
    check("first_pick", c, 0);
    drive(4'b0011, 1'b0);
    wait_idle(3000);
    check("post_rst_drained", sb.size(), 0);

`ifdef NEAREST_TRACK_EN
    // one sweep: 400 / 150 / timeout / 150
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    sweep_cnt = 0;
    cfg(0, 0, 20, 400, 16'd400, 1'b0);
    cfg(1, 0, 20, 150, 16'd150, 1'b0);
    cfg(2, 0, 0, 0, 16'hFFFF, 1'b1);
    cfg(3, 0, 20, 150, 16'd150, 1'b0);
    drive(4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) wait_trig(got[k], 2000);
    drive(4'b1111, 1'b0);
    wait_idle(3000);
    check("sweep_first_ch", got[0], 0);
    check("sweep_done_cnt", sweep_cnt, 1);
    check("nearest_count", nearest_count, 150);
    check("nearest_ch", nearest_ch, 1);
    check("sweep_drained", sb.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
